// File: rtl/snake_key_decoder.sv
//==============================================================================
// Module   : snake_key_decoder
// Purpose  : PS/2 scan-code decoder for a snake game. It produces make pulses,
//            held levels and a snake heading that cannot reverse onto itself.
// Options  : SNAKE_TYPEMATIC_FILTER_EN suppresses makes for keys already held.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module snake_key_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter bit          EXT_REQUIRED   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       code_valid,
    input  logic [7:0] code,
    output logic [7:0] cmd_pulse,
    output logic [7:0] cmd_held,
    output logic [1:0] dir,
    output logic       dir_changed
);

    localparam int unsigned CW = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
    localparam logic [CW-1:0] c_tmo_last = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    c_pfx_ext  = 8'hE0;
    localparam logic [7:0]    c_pfx_brk  = 8'hF0;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    pulse_q, pulse_d;
    logic [7:0]    held_q, held_d;
    logic [1:0]    dir_q, dir_d;
    logic          dchg_q, dchg_d;

    logic [7:0]    w_key;
    logic          w_is_arrow;
    logic [1:0]    w_req;
    logic          w_make, w_brk, w_ext;
    logic          w_accept, w_fresh, w_do_make;

    always_comb begin
        w_key = 8'h00;
        case (code)
            8'h1B:   w_key = 8'h01;
            8'h4D:   w_key = 8'h02;
            8'h2D:   w_key = 8'h04;
            8'h76:   w_key = 8'h08;
            8'h74:   w_key = 8'h10;
            8'h6B:   w_key = 8'h20;
            8'h75:   w_key = 8'h40;
            8'h72:   w_key = 8'h80;
            default: w_key = 8'h00;
        endcase
    end

    assign w_is_arrow = |w_key[7:4];
    // Heading encoding: rt 00, lf 01, up 10, dn 11.
    assign w_req      = {w_key[6] | w_key[7], w_key[5] | w_key[7]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_make  = 1'b0;
        w_brk   = 1'b0;
        w_ext   = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (code_valid) begin
                    if (code == c_pfx_ext)      state_d = S_EXT;
                    else if (code == c_pfx_brk) state_d = S_BRK;
                    else                        w_make  = 1'b1;
                end
            end
            default: begin
                if (code_valid) begin
                    cnt_d = '0;
                    if (state_q == S_EXT && code == c_pfx_ext) begin
                        state_d = S_EXT;
                    end else if (state_q == S_EXT && code == c_pfx_brk) begin
                        state_d = S_EXT_BRK;
                    end else if (state_q == S_BRK && code == c_pfx_brk) begin
                        state_d = S_BRK;
                    end else begin
                        state_d = S_IDLE;
                        w_ext   = (state_q == S_EXT) || (state_q == S_EXT_BRK);
                        w_make  = (state_q == S_EXT);
                        w_brk   = (state_q != S_EXT);
                    end
                end else if (cnt_q == c_tmo_last) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    assign w_accept = (|w_key) && (!EXT_REQUIRED || (w_is_arrow == w_ext));
`ifdef SNAKE_TYPEMATIC_FILTER_EN
    assign w_fresh  = ~|(held_q & w_key);
`else
    assign w_fresh  = 1'b1;
`endif
    assign w_do_make = w_make && w_accept && w_fresh;

    always_comb begin
        held_d  = held_q;
        pulse_d = 8'h00;
        dir_d   = dir_q;
        dchg_d  = 1'b0;
        if (w_make && w_accept) held_d = held_q | w_key;
        if (w_brk && w_accept)  held_d = held_q & ~w_key;
        if (w_do_make) begin
            pulse_d = w_key;
            // s recentres to the right regardless of the reversal rule.
            if (w_key[0] && dir_q != 2'b00) begin
                dir_d  = 2'b00;
                dchg_d = 1'b1;
            end else if (w_is_arrow && w_req != dir_q && w_req != {dir_q[1], ~dir_q[0]}) begin
                dir_d  = w_req;
                dchg_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pulse_q <= 8'h00;
            held_q  <= 8'h00;
            dir_q   <= 2'b00;
            dchg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            held_q  <= held_d;
            dir_q   <= dir_d;
            dchg_q  <= dchg_d;
        end
    end

    assign cmd_pulse   = pulse_q;
    assign cmd_held    = held_q;
    assign dir         = dir_q;
    assign dir_changed = dchg_q;

endmodule

`default_nettype wire

// File: tb/tb_snake_key_decoder.sv
//==============================================================================
// Module   : tb_snake_key_decoder
// Purpose  : Self-checking bench; two decoders (prefix required / optional)
//            share one byte stream and are checked against hand-derived values.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_snake_key_decoder;

    localparam int unsigned TMO = 16;
`ifdef SNAKE_TYPEMATIC_FILTER_EN
    localparam bit TYP = 1'b1;
`else
    localparam bit TYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       code_valid = 1'b0;
    logic [7:0] code = 8'h00;
    logic [7:0] a_pulse, a_held, b_pulse, b_held;
    logic [1:0] a_dir, b_dir;
    logic       a_dc, b_dc;

    always #5 clk = ~clk;

    snake_key_decoder #(.TIMEOUT_CYCLES(TMO), .EXT_REQUIRED(1'b1)) u_a (
        .clk(clk), .rst(rst), .code_valid(code_valid), .code(code),
        .cmd_pulse(a_pulse), .cmd_held(a_held), .dir(a_dir), .dir_changed(a_dc));

    snake_key_decoder #(.TIMEOUT_CYCLES(TMO), .EXT_REQUIRED(1'b0)) u_b (
        .clk(clk), .rst(rst), .code_valid(code_valid), .code(code),
        .cmd_pulse(b_pulse), .cmd_held(b_held), .dir(b_dir), .dir_changed(b_dc));

    typedef struct {
        logic       v;
        logic [7:0] code;
        logic [7:0] pa, ha;
        logic [1:0] da;
        logic       ca;
        logic [7:0] pb, hb;
        logic [1:0] db;
        logic       cb;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic v, input logic [7:0] c,
                                input logic [7:0] pa, input logic [7:0] ha,
                                input logic [1:0] da, input logic ca,
                                input logic [7:0] pb, input logic [7:0] hb,
                                input logic [1:0] db, input logic cb);
        vec_t t;
        t.v = v;   t.code = c;
        t.pa = pa; t.ha = ha; t.da = da; t.ca = ca;
        t.pb = pb; t.hb = hb; t.db = db; t.cb = cb;
        return t;
    endfunction

    task automatic add(input logic v, input logic [7:0] c,
                       input logic [7:0] pa, input logic [7:0] ha,
                       input logic [1:0] da, input logic ca,
                       input logic [7:0] pb, input logic [7:0] hb,
                       input logic [1:0] db, input logic cb);
        tbl.push_back(mk(v, c, pa, ha, da, ca, pb, hb, db, cb));
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " pulse_a"}, a_pulse, 8'h00);
        chk({tag, " held_a"},  a_held,  8'h00);
        chk({tag, " dir_a"},   {6'd0, a_dir}, 8'h00);
        chk({tag, " dc_a"},    {7'd0, a_dc},  8'h00);
        chk({tag, " pulse_b"}, b_pulse, 8'h00);
        chk({tag, " held_b"},  b_held,  8'h00);
        chk({tag, " dir_b"},   {6'd0, b_dir}, 8'h00);
        chk({tag, " dc_b"},    {7'd0, b_dc},  8'h00);
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic apply(input vec_t t, input string tag);
        vec_t e;
        @(negedge clk);
        code_valid = t.v;
        code       = t.code;
        sb.push_back(t);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, " pulse_a"}, a_pulse, e.pa);
        chk({tag, " held_a"},  a_held,  e.ha);
        chk({tag, " dir_a"},   {6'd0, a_dir}, {6'd0, e.da});
        chk({tag, " dc_a"},    {7'd0, a_dc},  {7'd0, e.ca});
        chk({tag, " pulse_b"}, b_pulse, e.pb);
        chk({tag, " held_b"},  b_held,  e.hb);
        chk({tag, " dir_b"},   {6'd0, b_dir}, {6'd0, e.db});
        chk({tag, " dc_b"},    {7'd0, b_dc},  {7'd0, e.cb});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //   v  code   pa     ha     da  ca  pb                    hb     db  cb
        add(1, 8'h1B, 8'h01, 8'h01, 0, 0, 8'h01,               8'h01, 0, 0);
        add(0, 8'h00, 8'h00, 8'h01, 0, 0, 8'h00,               8'h01, 0, 0);
        add(1, 8'hF0, 8'h00, 8'h01, 0, 0, 8'h00,               8'h01, 0, 0);
        add(1, 8'h1B, 8'h00, 8'h00, 0, 0, 8'h00,               8'h00, 0, 0);
        add(1, 8'hE0, 8'h00, 8'h00, 0, 0, 8'h00,               8'h00, 0, 0);
        add(1, 8'h6B, 8'h20, 8'h20, 0, 0, 8'h20,               8'h20, 0, 0);
        add(1, 8'hE0, 8'h00, 8'h20, 0, 0, 8'h00,               8'h20, 0, 0);
        add(1, 8'h75, 8'h40, 8'h60, 2, 1, 8'h40,               8'h60, 2, 1);
        add(1, 8'h75, 8'h00, 8'h60, 2, 0, TYP ? 8'h00 : 8'h40, 8'h60, 2, 0);
        add(1, 8'h72, 8'h00, 8'h60, 2, 0, 8'h80,               8'hE0, 2, 0);
        add(1, 8'hE0, 8'h00, 8'h60, 2, 0, 8'h00,               8'hE0, 2, 0);
        add(1, 8'hF0, 8'h00, 8'h60, 2, 0, 8'h00,               8'hE0, 2, 0);
        add(1, 8'h6B, 8'h00, 8'h40, 2, 0, 8'h00,               8'hC0, 2, 0);
        add(1, 8'h6B, 8'h00, 8'h40, 2, 0, 8'h20,               8'hE0, 1, 1);
        add(1, 8'h4D, 8'h02, 8'h42, 2, 0, 8'h02,               8'hE2, 1, 0);
        add(1, 8'h4D, TYP ? 8'h00 : 8'h02, 8'h42, 2, 0, TYP ? 8'h00 : 8'h02, 8'hE2, 1, 0);
        add(1, 8'h4D, TYP ? 8'h00 : 8'h02, 8'h42, 2, 0, TYP ? 8'h00 : 8'h02, 8'hE2, 1, 0);
        add(1, 8'h1B, 8'h01, 8'h43, 0, 1, 8'h01,               8'hE3, 0, 1);
        add(1, 8'hE0, 8'h00, 8'h43, 0, 0, 8'h00,               8'hE3, 0, 0);
        add(1, 8'hE0, 8'h00, 8'h43, 0, 0, 8'h00,               8'hE3, 0, 0);
        add(1, 8'h74, 8'h10, 8'h53, 0, 0, 8'h10,               8'hF3, 0, 0);
        add(1, 8'hF0, 8'h00, 8'h53, 0, 0, 8'h00,               8'hF3, 0, 0);
        add(1, 8'hF0, 8'h00, 8'h53, 0, 0, 8'h00,               8'hF3, 0, 0);
        add(1, 8'h4D, 8'h00, 8'h51, 0, 0, 8'h00,               8'hF1, 0, 0);
        add(1, 8'h2D, 8'h04, 8'h55, 0, 0, 8'h04,               8'hF5, 0, 0);
        add(1, 8'h99, 8'h00, 8'h55, 0, 0, 8'h00,               8'hF5, 0, 0);
        add(1, 8'hF0, 8'h00, 8'h55, 0, 0, 8'h00,               8'hF5, 0, 0);
        add(1, 8'h99, 8'h00, 8'h55, 0, 0, 8'h00,               8'hF5, 0, 0);
        add(1, 8'hE0, 8'h00, 8'h55, 0, 0, 8'h00,               8'hF5, 0, 0);
        add(1, 8'hF0, 8'h00, 8'h55, 0, 0, 8'h00,               8'hF5, 0, 0);
        add(1, 8'h75, 8'h00, 8'h15, 0, 0, 8'h00,               8'hB5, 0, 0);

        // Reset state, checked while reset is still held.
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

        // A byte on the last cycle before timeout still completes the prefix.
        apply(mk(1, 8'hE0, 8'h00, 8'h15, 0, 0, 8'h00, 8'hB5, 0, 0), "tmo_edge_e0");
        for (int i = 0; i < TMO - 1; i++)
            apply(mk(0, 8'h00, 8'h00, 8'h15, 0, 0, 8'h00, 8'hB5, 0, 0), "tmo_edge_wait");
        apply(mk(1, 8'h75, 8'h40, 8'h55, 2, 1, 8'h40, 8'hF5, 2, 1), "tmo_edge_up");
        apply(mk(1, 8'hE0, 8'h00, 8'h55, 2, 0, 8'h00, 8'hF5, 2, 0), "brk_e0");
        apply(mk(1, 8'hF0, 8'h00, 8'h55, 2, 0, 8'h00, 8'hF5, 2, 0), "brk_f0");
        apply(mk(1, 8'h75, 8'h00, 8'h15, 2, 0, 8'h00, 8'hB5, 2, 0), "brk_up");

        // One more idle cycle abandons the prefix; 75 then arrives unprefixed.
        apply(mk(1, 8'hE0, 8'h00, 8'h15, 2, 0, 8'h00, 8'hB5, 2, 0), "tmo_e0");
        for (int i = 0; i < TMO; i++)
            apply(mk(0, 8'h00, 8'h00, 8'h15, 2, 0, 8'h00, 8'hB5, 2, 0), "tmo_wait");
        apply(mk(1, 8'h75, 8'h00, 8'h15, 2, 0, 8'h40, 8'hF5, 2, 0), "tmo_up");

        // Asynchronous reset mid-prefix.
        apply(mk(1, 8'hE0, 8'h00, 8'h15, 2, 0, 8'h00, 8'hF5, 2, 0), "rst_e0");
        @(negedge clk);
        code_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("rst_async");
        @(posedge clk);
        #1;
        chk_all_zero("rst_hold");
        @(negedge clk);
        rst = 1'b0;
        apply(mk(1, 8'h74, 8'h00, 8'h00, 0, 0, 8'h10, 8'h10, 0, 0), "rst_rt");
        apply(mk(0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 8'h10, 0, 0), "rst_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/snake_key_decoder.md
SNAKE_KEY_DECODER -- requirements
Module: snake_key_decoder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50000: max cycles a prefix state (F0/E0) waits for the next byte before abandoning the sequence.
REQ-002 Parameter EXT_REQUIRED, default 1: 1 = arrow codes decode only after E0 prefix; 0 = arrow codes decode with or without E0.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 code_valid  input  1  one-cycle strobe; code holds a new PS/2 byte this cycle.
REQ-006 code  input  8  received scan-code byte.
REQ-007 cmd_pulse  output  8  one-cycle make pulses; bit order {dn,up,lf,rt,esc,r,p,s} (bit0 = s).
REQ-008 cmd_held  output  8  level per key, same bit order: 1 between make and break.
REQ-009 dir  output  2  current snake heading: 00 right, 01 left, 10 up, 11 down.
REQ-010 dir_changed  output  1  one-cycle pulse when dir updates.

Function
REQ-011 Codes: s 1B, p 4D, r 2D, esc 76, rt 74, lf 6B, up 75, dn 72 (hex); all other codes ignored with no output change.
REQ-012 FSM states IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0); bytes are consumed only when code_valid=1.
REQ-013 IDLE: E0 -> EXT; F0 -> BRK; mapped code -> make event, stay IDLE; other -> IDLE.
REQ-014 EXT: F0 -> EXT_BRK; any other byte -> make event (extended), IDLE.
REQ-015 BRK / EXT_BRK: any byte -> break event (extended for EXT_BRK), IDLE.
REQ-016 Make event: the key's cmd_pulse bit is 1 in the cycle after the code_valid cycle; cmd_held bit set the same cycle.
REQ-017 Break event: cmd_held bit cleared the cycle after code_valid; no cmd_pulse.
REQ-018 EXT_REQUIRED=1: arrow codes without E0, and non-arrow codes with E0, are ignored for make and break.
REQ-019 Prefix timeout: an 8-bit-plus counter clears on entry to any non-IDLE state and on each code_valid; when it reaches TIMEOUT_CYCLES-1 with no code_valid, the FSM returns to IDLE with no event.
REQ-020 A repeated E0 or F0 while in a prefix state is absorbed (EXT+E0 stays EXT; BRK+F0 stays BRK).
REQ-021 Direction: make of rt/lf/up/dn updates dir unless the request is the exact opposite of the current dir (rt<->lf, up<->dn) or equals it; on update dir_changed pulses with the cmd_pulse.
REQ-022 Make of s forces dir to right and pulses dir_changed if dir was not right; s overrides reversal rejection.
REQ-023 At most one cmd_pulse bit is high in any cycle.
REQ-024 cmd_pulse and dir_changed are registered; no combinational path from inputs to outputs.

Reset
REQ-025 rst asserted: FSM -> IDLE, timeout counter 0, cmd_pulse 0, cmd_held 0, dir 00, dir_changed 0, immediately and independent of clk.
REQ-026 rst mid-sequence (e.g. after E0) discards the prefix; the first byte after deassertion decodes from IDLE.

Configuration
REQ-027 Macro SNAKE_TYPEMATIC_FILTER_EN: when defined, a make for a key whose cmd_held bit is already 1 produces no cmd_pulse and no dir update; when undefined, every make (including typematic repeats) pulses.

Verification
REQ-028 Send 1B -> cmd_pulse=01 for one cycle, cmd_held[0]=1, dir=00; then F0,1B -> cmd_held[0]=0, no pulse.
REQ-029 dir=right, send E0,6B (left) -> no dir change; send E0,75 -> dir=10, dir_changed pulse, cmd_pulse bit6.
REQ-030 EXT_REQUIRED=1, send 75 without E0 -> no outputs change; EXT_REQUIRED=0 -> up pulse.
REQ-031 Send E0, then idle TIMEOUT_CYCLES cycles, then 75 -> FSM timed out, 75 treated as unprefixed (ignored when EXT_REQUIRED=1).
REQ-032 With SNAKE_TYPEMATIC_FILTER_EN defined, send 4D,4D,4D -> exactly one p pulse; undefined -> three pulses.
REQ-033 Send E0, assert rst for 1 cycle mid-clock, send 74 -> all outputs zero during reset, 74 ignored (EXT_REQUIRED=1).
